// File: rtl/core_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states,
// requester count, grant-index width and small index helpers.
package core_pkg;

  localparam int NUM_REQ = 3;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Round-robin successor over the three valid grant indices.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] s);
    logic [SEL_W-1:0] n;
    case (s)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_REQ-1:0] oh;
    case (s)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux31.sv
// Three-to-one mux steering one requester field onto the shared port.
module mux31
  import core_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [SEL_W-1:0] s,
  output logic [W-1:0]     y
);

  // Select 2'b11 is never driven by the arbiter; it yields zero.
  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among fetch, LSU and debug,
// tracking each transaction from grant to response with a timeout.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 64,
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [DATA_W-1:0]    req_addr0,
  input  logic [DATA_W-1:0]    req_addr1,
  input  logic [DATA_W-1:0]    req_addr2,
  input  logic [DATA_W-1:0]    req_wdata0,
  input  logic [DATA_W-1:0]    req_wdata1,
  input  logic [DATA_W-1:0]    req_wdata2,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic                 rsp_err,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 m_valid,
  output logic                 m_we,
  output logic [DATA_W-1:0]    m_addr,
  output logic [DATA_W-1:0]    m_wdata,
  input  logic                 m_ready,
  input  logic                 m_rvalid,
  input  logic [DATA_W-1:0]    m_rdata,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy
);

  arb_state_t          state_q, state_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  req_ready_s;
  logic                m_valid_s;
  logic                m_we_s;
  logic [SEL_W-1:0]    cand_s;
  logic [SEL_W-1:0]    win_s;
  logic                found_s;
  logic [TO_W-1:0]     cnt_inc_s;
  logic                to_hit_s;

  // Scan last+1, last+2, last for the first valid requester.
  always_comb begin
    cand_s  = last_q;
    win_s   = 2'd0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s  = rr_next(cand_s);
      win_s   = (!found_s && req_valid[cand_s]) ? cand_s : win_s;
      found_s = found_s | req_valid[cand_s];
    end
  end

  // A ">=" compare keeps RESP able to time out even when the handshake
  // consumed the TIMEOUT-1 cycle in REQ.
  assign cnt_inc_s = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);
  assign to_hit_s  = (cnt_q >= TO_W'(TIMEOUT - 1));

  // Next-state, counter, response capture and bus-side strobes.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    req_ready_s = '0;
    m_valid_s   = 1'b0;
    m_we_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          sel_d   = win_s;
          last_d  = win_s;
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        m_valid_s = 1'b1;
        m_we_s    = req_we[sel_q];
        cnt_d     = cnt_inc_s;
        if (m_ready) begin
          req_ready_s = sel_onehot(sel_q);
          state_d     = RESP;
        end else if (to_hit_s) begin
          req_ready_s = sel_onehot(sel_q);
          rsp_valid_d = sel_onehot(sel_q);
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        cnt_d = cnt_inc_s;
        if (m_rvalid) begin
          rsp_valid_d = sel_onehot(sel_q);
          rsp_rdata_d = m_rdata;
          state_d     = IDLE;
        end else if (to_hit_s) begin
          rsp_valid_d = sel_onehot(sel_q);
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, grant and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 2'd2;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  mux31 #(.W(DATA_W)) u_mux_addr (
    .d0 (req_addr0),
    .d1 (req_addr1),
    .d2 (req_addr2),
    .s  (sel_q),
    .y  (m_addr)
  );

  mux31 #(.W(DATA_W)) u_mux_wdata (
    .d0 (req_wdata0),
    .d1 (req_wdata1),
    .d2 (req_wdata2),
    .s  (sel_q),
    .y  (m_wdata)
  );

  assign req_ready = req_ready_s;
  assign m_valid   = m_valid_s;
  assign m_we      = m_we_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  sel;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr0  (addr_v[0]),
    .req_addr1  (addr_v[1]),
    .req_addr2  (addr_v[2]),
    .req_wdata0 (wdata_v[0]),
    .req_wdata1 (wdata_v[1]),
    .req_wdata2 (wdata_v[2]),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .m_valid    (m_valid),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata),
    .sel        (sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: who owns the port, how long since grant, accepted yet.
  int          m_owner, m_age, m_last, m_sel, m_rsp_own;
  bit          m_acc, m_rsp_err;
  logic [31:0] m_rsp_data;
  int          rst_events = 0;
  int          rst_seen   = 0;
  logic [2:0]  ack_last   = 3'b000;

  task automatic m_reset();
    m_owner = -1; m_age = 0; m_last = 2; m_sel = 0; m_acc = 0;
    m_rsp_own = -1; m_rsp_err = 0; m_rsp_data = 32'h0;
  endtask

  initial begin : compare
    bit          e_mv, e_tmo;
    logic [2:0]  e_rdy, e_rsp;
    m_reset();
    forever begin
      @(negedge clk); #4;
      if (rst_seen != rst_events) begin m_reset(); rst_seen = rst_events; end
      ack_last = req_ready;
      if (!rst_n) begin
        m_reset();
        chk("rst_sel", sel, 2'd0);        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_we", m_we, 1'b0);      chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 3'b000); chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);  chk("rst_busy", busy, 1'b0);
      end else begin
        e_mv  = (m_owner >= 0) && !m_acc;
        e_tmo = (m_age >= TO - 1);
        e_rdy = (e_mv && (m_ready || e_tmo)) ? 3'(1 << m_owner) : 3'b000;
        e_rsp = (m_rsp_own >= 0) ? 3'(1 << m_rsp_own) : 3'b000;
        chk("busy", busy, m_owner >= 0);
        chk("sel", sel, m_sel);
        chk("m_valid", m_valid, e_mv);
        chk("req_ready", req_ready, e_rdy);
        chk("rsp_valid", rsp_valid, e_rsp);
        if (e_mv) begin
          chk("m_we", m_we, req_we[m_owner]);
          chk("m_addr", m_addr, addr_v[m_owner]);
          chk("m_wdata", m_wdata, wdata_v[m_owner]);
          chk("protocol_hold", req_valid[m_owner], 1'b1);
        end
        if (m_rsp_own >= 0) begin
          chk("rsp_err", rsp_err, m_rsp_err);
          chk("rsp_rdata", rsp_rdata, m_rsp_data);
        end
        m_rsp_own = -1; m_rsp_err = 0; m_rsp_data = 32'h0;
        if (m_owner < 0) begin
          for (int k = 1; k <= 3; k++)
            if (m_owner < 0 && req_valid[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
          if (m_owner >= 0) begin m_last = m_owner; m_sel = m_owner; m_age = 0; m_acc = 0; end
        end else if (!m_acc) begin
          if (m_ready) begin m_acc = 1; m_age++; end
          else if (e_tmo) begin m_rsp_own = m_owner; m_rsp_err = 1; m_owner = -1; end
          else m_age++;
        end else begin
          if (m_rvalid) begin m_rsp_own = m_owner; m_rsp_data = m_rdata; m_owner = -1; end
          else if (e_tmo) begin m_rsp_own = m_owner; m_rsp_err = 1; m_owner = -1; end
          else m_age++;
        end
      end
    end
  end

  // Requesters hold their request until acknowledged, then re-issue or drop.
  int remaining [3];

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (ack_last[i] && remaining[i] > 0) begin
        remaining[i]--;
        if (remaining[i] > 0) begin
          addr_v[i]  = addr_v[i] + 32'h10;
          wdata_v[i] = ~wdata_v[i];
          req_we[i]  = ~req_we[i];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a, input int n);
    addr_v[i]    = a;
    wdata_v[i]   = a ^ 32'h5555_5555;
    req_we[i]    = i[0];
    remaining[i] = n;
    req_valid[i] = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin : driver
    int gl [6];
    int ng;
    rst_n = 1'b0; req_valid = 3'b000; req_we = 3'b000;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin addr_v[i] = 32'h0; wdata_v[i] = 32'h0; remaining[i] = 0; end
    tick(); tick();
    rst_n = 1'b1;

    // Single request from requester 1.
    tick();
    issue(1, 32'h1234_5678, 1); m_ready = 1'b1;
    tick(); #4;
    chk("t1_sel", sel, 2'b01);
    chk("t1_m_addr", m_addr, 32'h1234_5678);
    chk("t1_m_valid", m_valid, 1'b1);
    chk("t1_req_ready", req_ready, 3'b010);
    tick(); m_ready = 1'b0; #4;
    chk("t1_req_ready_once", req_ready, 3'b000);
    tick(); m_rvalid = 1'b1; m_rdata = 32'hBABE_FACE;
    tick(); m_rvalid = 1'b0; #4;
    chk("t1_rsp_valid", rsp_valid, 3'b010);
    chk("t1_rsp_rdata", rsp_rdata, 32'hBABE_FACE);
    chk("t1_rsp_err", rsp_err, 1'b0);

    // Reset, then all three requesting continuously.
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    issue(0, 32'h0000_1000, 2); issue(1, 32'h0000_2000, 2); issue(2, 32'h0000_3000, 2);
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0F0F_0001;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      tick(); m_rdata = m_rdata + 32'h1; #4;
      if (req_ready != 3'b000) begin
        gl[ng] = (req_ready == 3'b001) ? 0 : (req_ready == 3'b010) ? 1 : (req_ready == 3'b100) ? 2 : 3;
        ng++;
      end
    end
    chk("t2_grant_count", ng, 6);
    for (int g = 0; g < 6; g++) chk($sformatf("t2_grant_order%0d", g), gl[g], g % 3);
    repeat (3) tick();
    m_ready = 1'b0; m_rvalid = 1'b0;

    // Backpressure: five cycles without m_ready.
    tick();
    issue(2, 32'hA5A5_0002, 1);
    for (int j = 0; j < 5; j++) begin
      tick(); #4;
      chk("t3_m_valid", m_valid, 1'b1);
      chk("t3_m_addr", m_addr, 32'hA5A5_0002);
      chk("t3_sel", sel, 2'b10);
      chk("t3_no_ready", req_ready, 3'b000);
    end
    tick(); m_ready = 1'b1; #4;
    chk("t3_req_ready", req_ready, 3'b100);
    tick(); m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1357_9BDF;
    tick(); m_rvalid = 1'b0; #4;
    chk("t3_rsp_valid", rsp_valid, 3'b100);
    chk("t3_rsp_rdata", rsp_rdata, 32'h1357_9BDF);

    // Timeout in RESP: accepted, never answered.
    tick();
    issue(0, 32'h0000_0A00, 1); m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
    for (int j = 1; j <= 8; j++) tick();
    #4;
    chk("t4_no_early_rsp", rsp_valid, 3'b000);
    chk("t4_busy", busy, 1'b1);
    tick(); #4;
    chk("t4_rsp_valid", rsp_valid, 3'b001);
    chk("t4_rsp_err", rsp_err, 1'b1);
    chk("t4_rsp_rdata", rsp_rdata, 32'h0);
    chk("t4_idle", busy, 1'b0);

    // Timeout in REQ: m_ready never asserted.
    tick();
    issue(1, 32'h0000_0B00, 1); m_ready = 1'b0;
    for (int j = 1; j <= 8; j++) tick();
    #4;
    chk("t4b_req_ready", req_ready, 3'b010);
    chk("t4b_m_valid", m_valid, 1'b1);
    tick(); #4;
    chk("t4b_m_valid_drop", m_valid, 1'b0);
    chk("t4b_rsp_valid", rsp_valid, 3'b010);
    chk("t4b_rsp_err", rsp_err, 1'b1);

    // Collision: m_rvalid in the timeout cycle.
    tick();
    issue(2, 32'h0000_0C00, 1); m_ready = 1'b1;
    for (int j = 1; j <= 7; j++) tick();
    tick(); m_rvalid = 1'b1; m_rdata = 32'hC0FF_EE11;
    tick(); m_rvalid = 1'b0; #4;
    chk("t5_rsp_valid", rsp_valid, 3'b100);
    chk("t5_rsp_err", rsp_err, 1'b0);
    chk("t5_rsp_rdata", rsp_rdata, 32'hC0FF_EE11);

    // Asynchronous reset pulse during RESP.
    tick();
    issue(1, 32'h0000_0D00, 1); m_ready = 1'b1;
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_m_valid", m_valid, 1'b0);
    chk("t6_req_ready", req_ready, 3'b000);
    chk("t6_rsp_valid", rsp_valid, 3'b000);
    chk("t6_busy", busy, 1'b0);
    chk("t6_sel", sel, 2'b00);
    chk("t6_rsp_err", rsp_err, 1'b0);
    rst_events++;
    #1 rst_n = 1'b1;
    tick(); m_rvalid = 1'b1; m_rdata = 32'h7777_0000;
    issue(0, 32'h0000_0E00, 1); issue(1, 32'h0000_0E10, 1); issue(2, 32'h0000_0E20, 1);
    #4;
    chk("t6_no_rsp", rsp_valid, 3'b000);
    tick(); #4;
    chk("t6_first_grant", sel, 2'b00);
    chk("t6_first_m_valid", m_valid, 1'b1);
    repeat (12) tick();
    m_ready = 1'b0; m_rvalid = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
